qs_bank_sched: RTL and testbench

QS_BANK_SCHED -- requirements
Module: qs_bank_sched

---
 rtl/qs_bank_sched_if.sv | 17 +
 rtl/qs_bank_sched.sv | 161 ++++++++++++++++
 tb/tb_qs_bank_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qs_bank_sched_if.sv
// Agent-side bus of the bank scheduler: per-agent bank select, update strobe and
// proposed bank_state, plus the registered bank_state each agent currently sees.
interface qs_bank_sched_if #(
   parameter int BANKS = 4,
   parameter int N_W   = 10
);
   localparam int BW = $clog2(BANKS);
   localparam int SW = 3 + N_W;

   logic [2:0][BW-1:0] agent_bank;
   logic [2:0]         upd_vld;
   logic [2:0][SW-1:0] upd_state;
   logic [2:0][SW-1:0] view_state;

   modport master (output agent_bank, upd_vld, upd_state, input view_state);
   modport slave  (input agent_bank, upd_vld, upd_state, output view_state);
endinterface

// File: rtl/qs_bank_sched.sv
// Bank status table shared by enq/sort/deq agents, with a round-robin scheduler
// that hands READY banks to the sort engine one at a time.
module qs_bank_sched #(
   parameter  int BANKS = 4,
   parameter  int N_W   = 10,
   localparam int BW    = $clog2(BANKS),
   localparam int SW    = 3 + N_W
) (
   input  logic           clk,
   input  logic           rst,
   qs_bank_sched_if.slave bus,
   output logic           sort_gnt_vld_r,
   output logic [BW-1:0]  sort_gnt_bank_r,
   output logic [BW:0]    idle_cnt_r,
   output logic           err_r,
   output logic [1:0]     err_agent_r
);
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOADING   = 3'd1;
   localparam logic [2:0] ST_READY     = 3'd2;
   localparam logic [2:0] ST_SORTING   = 3'd3;
   localparam logic [2:0] ST_SORTED    = 3'd4;
   localparam logic [2:0] ST_UNLOADING = 3'd5;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;

   localparam int AG_ENQ  = 0;
   localparam int AG_SORT = 1;
   localparam int AG_DEQ  = 2;

   logic [BANKS-1:0][2:0]     status_r, status_nx;
   logic [BANKS-1:0][N_W-1:0] n_r, n_nx;
   logic [1:0]                fsm_r;
   logic [BW-1:0]             rr_ptr_r;

   logic [2:0][2:0] cur_st, new_st;
   logic [2:0]      lost, upd_ok, upd_bad;
   logic [1:0]      first_bad;
   logic            pick_vld, sched_wr;
   logic [BW-1:0]   pick, idx;
   logic [BW:0]     idle_nx;

   function automatic logic legal_tr(input int agent, input logic [2:0] from, input logic [2:0] to);
      logic ok;
      case (agent)
         AG_ENQ:  ok = (from == ST_IDLE && to == ST_LOADING) ||
                       (from == ST_LOADING && (to == ST_LOADING || to == ST_READY));
         AG_SORT: ok = (from == ST_SORTING && (to == ST_SORTING || to == ST_SORTED));
         AG_DEQ:  ok = (from == ST_SORTED && to == ST_UNLOADING) ||
                       (from == ST_UNLOADING && (to == ST_UNLOADING || to == ST_IDLE));
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Agents only ever see registered state; same-cycle updates are not bypassed.
   always_comb begin
      for (int a = 0; a < 3; a++) begin
         cur_st[a]          = status_r[bus.agent_bank[a]];
         new_st[a]          = bus.upd_state[a][SW-1:N_W];
         bus.view_state[a]  = {status_r[bus.agent_bank[a]], n_r[bus.agent_bank[a]]};
      end
   end

   // Same-bank collisions resolve deq > sort > enq; the losers count as illegal.
   always_comb begin
      lost[AG_DEQ]  = 1'b0;
      lost[AG_SORT] = bus.upd_vld[AG_DEQ] && (bus.agent_bank[AG_DEQ] == bus.agent_bank[AG_SORT]);
      lost[AG_ENQ]  = (bus.upd_vld[AG_DEQ]  && (bus.agent_bank[AG_DEQ]  == bus.agent_bank[AG_ENQ])) ||
                      (bus.upd_vld[AG_SORT] && (bus.agent_bank[AG_SORT] == bus.agent_bank[AG_ENQ]));
      for (int a = 0; a < 3; a++) begin
         upd_ok[a]  = bus.upd_vld[a] && !lost[a] && legal_tr(a, cur_st[a], new_st[a]);
         upd_bad[a] = bus.upd_vld[a] && !upd_ok[a];
      end
      first_bad = upd_bad[0] ? 2'd0 : (upd_bad[1] ? 2'd1 : 2'd2);
   end

   // Walk offsets high-to-low so the READY bank closest to rr_ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick     = rr_ptr_r;
      idx      = '0;
      for (int k = BANKS - 1; k >= 0; k--) begin
         idx = rr_ptr_r + BW'(k);
         if (status_r[idx] == ST_READY) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

   assign sched_wr = (fsm_r == S_IDLE) && pick_vld;

   // A READY bank admits no legal agent update, so the scheduler write never
   // collides with a committed agent write.
   always_comb begin
      status_nx = status_r;
      n_nx      = n_r;
      for (int a = 0; a < 3; a++) begin
         if (upd_ok[a]) begin
            status_nx[bus.agent_bank[a]] = new_st[a];
            n_nx[bus.agent_bank[a]]      = bus.upd_state[a][N_W-1:0];
         end
      end
      if (sched_wr)
         status_nx[pick] = ST_SORTING;
      idle_nx = '0;
      for (int b = 0; b < BANKS; b++)
         idle_nx = idle_nx + (BW+1)'(status_nx[b] == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_r    <= '0;
         n_r         <= '0;
         idle_cnt_r  <= (BW+1)'(BANKS);
         err_r       <= 1'b0;
         err_agent_r <= 2'd0;
      end else begin
         status_r   <= status_nx;
         n_r        <= n_nx;
         idle_cnt_r <= idle_nx;
         if (|upd_bad) begin
            err_r <= 1'b1;
            if (!err_r)
               err_agent_r <= first_bad;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_r           <= S_IDLE;
         rr_ptr_r        <= '0;
         sort_gnt_vld_r  <= 1'b0;
         sort_gnt_bank_r <= '0;
      end else begin
         sort_gnt_vld_r <= 1'b0;
         case (fsm_r)
            S_IDLE: begin
               if (pick_vld) begin
                  fsm_r           <= S_GRANT;
                  sort_gnt_bank_r <= pick;
                  sort_gnt_vld_r  <= 1'b1;
               end
            end
            S_GRANT: begin
               fsm_r    <= S_BUSY;
               rr_ptr_r <= sort_gnt_bank_r + BW'(1);
            end
            S_BUSY: begin
               if (status_r[sort_gnt_bank_r] != ST_SORTING)
                  fsm_r <= S_IDLE;
            end
            default: fsm_r <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qs_bank_sched.sv
// Bench for qs_bank_sched: directed walk through the bank lifecycle, then random
// agent traffic compared every cycle against a transaction-level model.
module tb_qs_bank_sched;
   localparam int BANKS = 4;
   localparam int N_W   = 10;
   localparam int BW    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #10 clk = ~clk;

   qs_bank_sched_if #(.BANKS(BANKS), .N_W(N_W)) bus ();

   logic          sort_gnt_vld_r;
   logic [BW-1:0] sort_gnt_bank_r;
   logic [BW:0]   idle_cnt_r;
   logic          err_r;
   logic [1:0]    err_agent_r;

   qs_bank_sched #(.BANKS(BANKS), .N_W(N_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sort_gnt_vld_r(sort_gnt_vld_r), .sort_gnt_bank_r(sort_gnt_bank_r),
      .idle_cnt_r(idle_cnt_r), .err_r(err_r), .err_agent_r(err_agent_r)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // (agent, from, to) triples that an agent may request.
   int legal_tab [8][3] = '{'{0,0,1}, '{0,1,1}, '{0,1,2}, '{1,3,3},
                            '{1,3,4}, '{2,4,5}, '{2,5,5}, '{2,5,0}};

   // Model state: plain integers per bank plus scheduler bookkeeping.
   int m_st [BANKS];
   int m_n  [BANKS];
   int m_rr, m_gnt_bank, m_idle, m_agent;
   bit m_gnt_vld, m_err, m_grant_last, m_sorting_last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input int a, input int from, input int to);
      for (int i = 0; i < 8; i++)
         if (legal_tab[i][0] == a && legal_tab[i][1] == from && legal_tab[i][2] == to) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_reset();
      for (int b = 0; b < BANKS; b++) begin m_st[b] = 0; m_n[b] = 0; end
      m_rr = 0; m_gnt_bank = 0; m_idle = BANKS; m_agent = 0;
      m_gnt_vld = 0; m_err = 0; m_grant_last = 0; m_sorting_last = 0;
   endtask

   // The scheduler may grant only if last cycle had no grant and no bank sorting.
   task automatic m_step();
      int ns [BANKS];
      int nn [BANKS];
      bit any_bad, grant, sorting_now;
      int first_bad, pick;
      ns = m_st; nn = m_n;
      any_bad = 0; first_bad = 0; grant = 0; pick = 0; sorting_now = 0;
      for (int b = 0; b < BANKS; b++) if (m_st[b] == 3) sorting_now = 1;
      for (int a = 0; a < 3; a++) begin
         int bk, to;
         bit lose;
         if (!bus.upd_vld[a]) continue;
         bk = int'(bus.agent_bank[a]);
         to = int'(bus.upd_state[a][N_W+2:N_W]);
         lose = 0;
         for (int h = a + 1; h < 3; h++)
            if (bus.upd_vld[h] && int'(bus.agent_bank[h]) == bk) lose = 1;
         if (!lose && is_legal(a, m_st[bk], to)) begin
            ns[bk] = to;
            nn[bk] = int'(bus.upd_state[a][N_W-1:0]);
         end else begin
            if (!any_bad) first_bad = a;
            any_bad = 1;
         end
      end
      if (!m_grant_last && !m_sorting_last)
         for (int k = 0; k < BANKS && !grant; k++)
            if (m_st[(m_rr + k) % BANKS] == 2) begin grant = 1; pick = (m_rr + k) % BANKS; end
      if (grant) begin
         ns[pick] = 3; m_gnt_bank = pick; m_rr = (pick + 1) % BANKS;
      end
      m_gnt_vld = grant;
      if (any_bad) begin
         if (!m_err) m_agent = first_bad;
         m_err = 1;
      end
      m_grant_last = grant; m_sorting_last = sorting_now;
      m_st = ns; m_n = nn;
      m_idle = 0;
      for (int b = 0; b < BANKS; b++) if (m_st[b] == 0) m_idle++;
   endtask

   always @(posedge clk) begin
      if (!rst) m_reset();
      else m_step();
   end

   always @(negedge clk) begin
      if (chk_en && rst) begin
         chk("gnt_vld", 32'(sort_gnt_vld_r), m_gnt_vld);
         chk("gnt_bank", 32'(sort_gnt_bank_r), m_gnt_bank);
         chk("idle_cnt", 32'(idle_cnt_r), m_idle);
         chk("err", 32'(err_r), m_err);
         chk("err_agent", 32'(err_agent_r), m_agent);
         for (int a = 0; a < 3; a++) begin
            int b;
            b = int'(bus.agent_bank[a]);
            chk("view_state", 32'(bus.view_state[a]), m_st[b] * (1 << N_W) + m_n[b]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.upd_vld = '0;
   endtask

   task automatic drive(input int a, input int b, input int s, input int n);
      bus.agent_bank[a] = BW'(b);
      bus.upd_vld[a]    = 1'b1;
      bus.upd_state[a]  = {3'(s), N_W'(n)};
   endtask

   task automatic step1(input int a, input int b, input int s, input int n);
      idle_in();
      drive(a, b, s, n);
      cyc();
      idle_in();
   endtask

   task automatic look(input int b, output int st, output int nv);
      bus.agent_bank[2] = BW'(b);
      #1;
      st = int'(bus.view_state[2][N_W+2:N_W]);
      nv = int'(bus.view_state[2][N_W-1:0]);
   endtask

   task automatic wait_gnt(input int b, input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cyc();
         seen = sort_gnt_vld_r;
      end
      chk({nm, "_vld"}, 32'(sort_gnt_vld_r), 1);
      chk({nm, "_bank"}, 32'(sort_gnt_bank_r), b);
   endtask

   task automatic rand_drive();
      for (int a = 0; a < 3; a++) begin
         int b, s, nv;
         int cands[$];
         b = $urandom_range(0, BANKS - 1);
         bus.agent_bank[a] = BW'(b);
         bus.upd_vld[a]    = ($urandom_range(0, 9) < 6);
         for (int i = 0; i < 8; i++)
            if (legal_tab[i][0] == a && legal_tab[i][1] == m_st[b]) cands.push_back(legal_tab[i][2]);
         if (cands.size() > 0 && $urandom_range(0, 9) < 8)
            s = cands[$urandom_range(0, cands.size() - 1)];
         else
            s = $urandom_range(0, 7);
         case ($urandom_range(0, 3))
            0:       nv = 0;
            1:       nv = (1 << N_W) - 1;
            default: nv = $urandom_range(0, (1 << N_W) - 1);
         endcase
         bus.upd_state[a] = {3'(s), N_W'(nv)};
      end
   endtask

   initial begin
      int st, nv;
      bus.agent_bank = '0;
      bus.upd_vld    = '0;
      bus.upd_state  = '0;
      m_reset();
      cyc(); cyc();
      rst = 1'b1;

      // reset state
      chk("rst_idle_cnt", 32'(idle_cnt_r), 4);
      chk("rst_err", 32'(err_r), 0);
      chk("rst_gnt_vld", 32'(sort_gnt_vld_r), 0);
      chk("model_idle_rst", m_idle, 4);
      for (int b = 0; b < BANKS; b++) begin
         look(b, st, nv);
         chk("rst_view_status", st, 0);
      end
      chk_en = 1'b1;

      // single bank: enq to READY, grant two cycles after the READY update
      step1(0, 0, 1, 5);
      step1(0, 0, 2, 5);
      cyc();
      chk("g0_vld", 32'(sort_gnt_vld_r), 1);
      chk("g0_bank", 32'(sort_gnt_bank_r), 0);
      chk("g0_idle_cnt", 32'(idle_cnt_r), 3);
      chk("model_gnt_bank", m_gnt_bank, 0);
      chk("model_idle", m_idle, 3);
      look(0, st, nv);
      chk("g0_status", st, 3);
      chk("g0_n", nv, 5);
      cyc();
      chk("g0_pulse_end", 32'(sort_gnt_vld_r), 0);
      step1(1, 0, 4, 5);
      step1(2, 0, 5, 5);
      step1(2, 0, 0, 0);

      // round robin: bank1 granted moves pointer to 2, so bank3 beats bank0
      step1(0, 1, 1, 7);
      step1(0, 1, 2, 7);
      wait_gnt(1, "g1");
      step1(0, 3, 1, 3);
      step1(0, 3, 2, 3);
      step1(0, 0, 1, 9);
      step1(0, 0, 2, 9);
      look(3, st, nv);
      chk("rr_b3_ready", st, 2);
      look(0, st, nv);
      chk("rr_b0_ready", st, 2);
      step1(1, 1, 4, 7);
      wait_gnt(3, "rr_first");
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rr_hold", 32'(sort_gnt_vld_r), 0);
      end
      step1(1, 3, 4, 3);
      wait_gnt(0, "rr_second");
      step1(1, 0, 4, 9);

      // deq and enq collide on bank2: deq wins, enq flagged
      step1(0, 2, 1, 2);
      step1(0, 2, 2, 2);
      wait_gnt(2, "g2");
      step1(1, 2, 4, 2);
      step1(2, 2, 5, 2);
      idle_in();
      drive(2, 2, 0, 0);
      drive(0, 2, 1, 4);
      cyc();
      idle_in();
      look(2, st, nv);
      chk("coll_status", st, 0);
      chk("coll_err", 32'(err_r), 1);
      chk("coll_err_agent", 32'(err_agent_r), 0);
      chk("coll_idle_cnt", 32'(idle_cnt_r), 1);

      // reset while the scheduler is busy
      step1(0, 2, 1, 1);
      step1(0, 2, 2, 1);
      wait_gnt(2, "g3");
      cyc();
      rst = 1'b0;
      #1;
      chk("midrst_idle_cnt", 32'(idle_cnt_r), 4);
      chk("midrst_gnt_vld", 32'(sort_gnt_vld_r), 0);
      chk("midrst_err", 32'(err_r), 0);
      cyc();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("midrst_no_gnt", 32'(sort_gnt_vld_r), 0);
      end

      // illegal deq SORTED->SORTED, then a later enq error keeps agent 2
      step1(0, 0, 1, 6);
      step1(0, 0, 2, 6);
      wait_gnt(0, "g4");
      step1(1, 0, 4, 6);
      step1(2, 0, 4, 6);
      look(0, st, nv);
      chk("ill_status", st, 4);
      chk("ill_n", nv, 6);
      chk("ill_err", 32'(err_r), 1);
      chk("ill_err_agent", 32'(err_agent_r), 2);
      step1(0, 1, 2, 0);
      chk("ill2_err_agent", 32'(err_agent_r), 2);
      look(1, st, nv);
      chk("ill2_status", st, 0);

      // two legal updates to distinct banks commit together
      idle_in();
      drive(0, 1, 1, 1023);
      drive(2, 0, 5, 6);
      cyc();
      idle_in();
      look(1, st, nv);
      chk("dual_b1_status", st, 1);
      chk("dual_b1_n", nv, 1023);
      look(0, st, nv);
      chk("dual_b0_status", st, 5);

      // random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            idle_in();
            rst = 1'b0;
            cyc();
            rst = 1'b1;
         end
         rand_drive();
         cyc();
      end
      idle_in();
      cyc();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
